// File: rtl/melody_pkg.sv
// ============================================================================
// Module  : melody_pkg
// Brief   : Shared types, table geometry and the stored song for the melody
//           sequencer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package melody_pkg;

    localparam int NOTES   = 8;
    localparam int LEN     = 16;
    localparam int DUR_W   = 4;
    localparam int NOTE_W  = $clog2(NOTES);
    localparam int ADDR_W  = $clog2(LEN);
    localparam int IDX_W   = ADDR_W + 1;
    localparam int ENTRY_W = NOTE_W + DUR_W;

    typedef enum logic [NOTE_W-1:0] {
        NOTE_C    = 3'd0,
        NOTE_D    = 3'd1,
        NOTE_E    = 3'd2,
        NOTE_F    = 3'd3,
        NOTE_G    = 3'd4,
        NOTE_A    = 3'd5,
        NOTE_BB   = 3'd6,
        NOTE_REST = 3'd7
    } note_e;

    typedef struct packed {
        note_e             note;
        logic [DUR_W-1:0]  dur;
    } entry_t;

    typedef entry_t [LEN-1:0] song_t;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_PLAY = 3'd2,
        S_GAP  = 3'd3,
        S_ADV  = 3'd4,
        S_DONE = 3'd5
    } state_e;

    function automatic entry_t mk_entry(note_e n, int unsigned d);
        entry_t e;
        e.note = n;
        e.dur  = d[DUR_W-1:0];
        return e;
    endfunction

    // Unused tail entries stay zero, which doubles as the end-of-song marker.
    function automatic song_t default_song();
        song_t s;
        s     = '0;
        s[0]  = mk_entry(NOTE_C, 2);
        s[1]  = mk_entry(NOTE_D, 2);
        s[2]  = mk_entry(NOTE_E, 2);
        s[3]  = mk_entry(NOTE_C, 2);
        s[4]  = mk_entry(NOTE_E, 2);
        s[5]  = mk_entry(NOTE_F, 2);
        s[6]  = mk_entry(NOTE_G, 4);
        s[7]  = mk_entry(NOTE_REST, 2);
        s[8]  = mk_entry(NOTE_G, 1);
        s[9]  = mk_entry(NOTE_A, 1);
        s[10] = mk_entry(NOTE_BB, 2);
        s[11] = mk_entry(NOTE_C, 4);
        return s;
    endfunction

    localparam song_t SONG = default_song();

endpackage

`default_nettype wire

// File: rtl/melody_rom.sv
// ============================================================================
// Module  : melody_rom
// Brief   : Combinational note-table lookup; the table is a parameter so a
//           different song is just a different constant.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module melody_rom
    import melody_pkg::*;
#(
    parameter song_t SONG_TBL = SONG
) (
    input  logic [ADDR_W-1:0]  addr,
    output logic [ENTRY_W-1:0] entry
);

    assign entry = SONG_TBL[addr];

endmodule

`default_nettype wire

// File: rtl/melody_sequencer.sv
// ============================================================================
// Module  : melody_sequencer
// Brief   : Steps through the note table, gating one gamma line onto the
//           buzzer for each note's beat count, with a silent gap after it.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module melody_sequencer
    import melody_pkg::*;
#(
    parameter int    GAP_BEATS = 1,
    parameter song_t SONG_TBL  = SONG
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [NOTES-1:0]  gamma,
    input  logic              start,
    input  logic              stop,
    input  logic              loop,
    output logic              tone,
    output logic              busy,
    output logic [ADDR_W-1:0] note_idx,
    output logic              done
);

    localparam int               GAP_W    = (GAP_BEATS > 1) ? $clog2(GAP_BEATS) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_BEATS - 1);
    localparam logic [IDX_W-1:0] IDX_END  = IDX_W'(LEN);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q,   idx_d;
    logic [NOTE_W-1:0]  note_q,  note_d;
    logic [DUR_W-1:0]   beat_q,  beat_d;
    logic [GAP_W-1:0]   gap_q,   gap_d;
    logic               tone_q,  tone_d;

    logic [ENTRY_W-1:0] rom_data;
    entry_t             entry;
    logic               end_of_song;

    melody_rom #(
        .SONG_TBL (SONG_TBL)
    ) u_rom (
        .addr  (idx_q[ADDR_W-1:0]),
        .entry (rom_data)
    );

    assign entry = entry_t'(rom_data);
    // The extra pointer bit marks running off the end of the table.
    assign end_of_song = (entry.dur == '0) || (idx_q >= IDX_END);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        note_d  = note_q;
        beat_d  = beat_q;
        gap_d   = gap_q;
        tone_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                    idx_d   = '0;
                end
            end
            S_LOAD: begin
                if (end_of_song) begin
                    // Restarting from entry 0 only when not already there keeps an empty table from spinning.
                    if (loop && (idx_q != '0)) begin
                        idx_d = '0;
                    end else begin
                        state_d = S_DONE;
                    end
                end else begin
                    note_d  = entry.note;
                    beat_d  = entry.dur;
                    state_d = S_PLAY;
                end
            end
            S_PLAY: begin
                if (en) begin
                    beat_d = beat_q - 1'b1;
                    if (beat_q == DUR_W'(1)) begin
                        if (GAP_BEATS > 0) begin
                            state_d = S_GAP;
                            gap_d   = '0;
                        end else begin
                            state_d = S_ADV;
                        end
                    end
                end
            end
            S_GAP: begin
                if (en) begin
                    gap_d = gap_q + 1'b1;
                    if (gap_q == GAP_LAST) begin
                        state_d = S_ADV;
                    end
                end
            end
            S_ADV: begin
                idx_d   = (idx_q >= IDX_END) ? idx_q : idx_q + 1'b1;
                state_d = S_LOAD;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (stop) begin
            state_d = S_IDLE;
        end

        // Keyed on the next state so tone_q can only be non-zero while state_q is PLAY.
        if ((state_d == S_PLAY) && (note_d != NOTE_REST)) begin
            tone_d = gamma[note_d];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            note_q  <= '0;
            beat_q  <= '0;
            gap_q   <= '0;
            tone_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            note_q  <= note_d;
            beat_q  <= beat_d;
            gap_q   <= gap_d;
            tone_q  <= tone_d;
        end
    end

    assign tone     = tone_q;
    assign busy     = (state_q == S_LOAD) || (state_q == S_PLAY) || (state_q == S_GAP);
    assign done     = (state_q == S_DONE);
    assign note_idx = idx_q[ADDR_W-1:0];

endmodule

`default_nettype wire

// File: tb/tb_melody_sequencer.sv
// ============================================================================
// Module  : tb_melody_sequencer
// Brief   : Scoreboard bench for melody_sequencer with three song tables.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_melody_sequencer;
    import melody_pkg::*;

    function automatic song_t song_two();
        song_t s;
        s    = '0;
        s[0] = mk_entry(NOTE_C, 2);
        s[1] = mk_entry(NOTE_E, 1);
        return s;
    endfunction

    function automatic song_t song_rest();
        song_t s;
        s    = '0;
        s[0] = mk_entry(NOTE_REST, 3);
        s[1] = mk_entry(NOTE_G, 1);
        return s;
    endfunction

    localparam song_t SONG_A = song_two();
    localparam song_t SONG_B = song_rest();
    localparam song_t SONG_E = '0;

    logic              clk   = 1'b0;
    logic              rst_n = 1'b0;
    logic              en    = 1'b0;
    logic              stop  = 1'b0;
    logic              loop  = 1'b0;
    logic [2:0]        start = '0;
    logic [7:0]        lfsr  = 8'hA5;
    logic [NOTES-1:0]  gamma;
    logic [NOTES-1:0]  gsamp = '0;
    logic [2:0]        tone, busy, done;
    logic [ADDR_W-1:0] idx_o [3];

    logic win = 1'b0;
    logic chk = 1'b0;

    typedef struct {
        int                dut;
        int                src;
        logic              busy;
        logic [ADDR_W-1:0] idx;
    } rec_t;

    rec_t sb[$];
    int   done_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    always @(posedge clk) lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    assign gamma = lfsr;
    always @(posedge clk) gsamp <= gamma;

    melody_sequencer #(.GAP_BEATS(1), .SONG_TBL(SONG_A)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .en(en), .gamma(gamma), .start(start[0]),
        .stop(stop), .loop(loop), .tone(tone[0]), .busy(busy[0]),
        .note_idx(idx_o[0]), .done(done[0])
    );

    melody_sequencer #(.GAP_BEATS(1), .SONG_TBL(SONG_B)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .en(en), .gamma(gamma), .start(start[1]),
        .stop(stop), .loop(loop), .tone(tone[1]), .busy(busy[1]),
        .note_idx(idx_o[1]), .done(done[1])
    );

    melody_sequencer #(.GAP_BEATS(1), .SONG_TBL(SONG_E)) u_dut_e (
        .clk(clk), .rst_n(rst_n), .en(en), .gamma(gamma), .start(start[2]),
        .stop(stop), .loop(loop), .tone(tone[2]), .busy(busy[2]),
        .note_idx(idx_o[2]), .done(done[2])
    );

    task automatic cmp(input string name, input int dut, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s dut=%0d t=%0t got=%0h want=%0h", name, dut, $time, got, want);
        end
    endtask

    // Monitor: done pulses, silence while not busy, and scoreboard records.
    always @(negedge clk) begin
        rec_t r;
        int   e;
        logic exp_tone;
        for (int d = 0; d < 3; d++) begin
            if (done[d] === 1'b1) begin
                if (done_q.size() == 0) begin
                    cmp("done_unexpected", d, 1, 0);
                end else begin
                    e = done_q.pop_front();
                    cmp("done_owner", d, d, e);
                end
            end
            if (busy[d] === 1'b0) begin
                cmp("tone_silent_idle", d, {31'b0, tone[d]}, 0);
            end
        end
        if (win || en || chk) begin
            if (sb.size() == 0) begin
                cmp("sb_underflow", -1, 1, 0);
            end else begin
                r        = sb[0];
                exp_tone = (r.src < 0) ? 1'b0 : gsamp[r.src];
                cmp("tone", r.dut, {31'b0, tone[r.dut]}, {31'b0, exp_tone});
                if (en || chk) begin
                    cmp("busy", r.dut, {31'b0, busy[r.dut]}, {31'b0, r.busy});
                    cmp("note_idx", r.dut, {28'b0, idx_o[r.dut]}, {28'b0, r.idx});
                    void'(sb.pop_front());
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int d, input int s, input logic b, input int i);
        rec_t r;
        r.dut  = d;
        r.src  = s;
        r.busy = b;
        r.idx  = i[ADDR_W-1:0];
        sb.push_back(r);
    endtask

    task automatic start_song(input int d);
        tick();
        en       = 1'b0;
        win      = 1'b0;
        start[d] = 1'b1;
        tick();
        start[d] = 1'b0;
    endtask

    // One beat: 10 clocks, en on the last; src<0 means silent.
    task automatic beat(input int d, input int s, input logic b, input int i);
        push(d, s, b, i);
        for (int k = 0; k < 10; k++) begin
            tick();
            en  = (k == 9);
            win = (k >= 3);
        end
    endtask

    task automatic check_now(input int d, input int i);
        push(d, -1, 1'b0, i);
        chk = 1'b1;
        tick();
        chk = 1'b0;
    endtask

    initial begin
        // Reset state of all three instances
        repeat (3) tick();
        for (int d = 0; d < 3; d++) check_now(d, 0);
        rst_n = 1'b1;
        tick();

        // Two-note song, one-beat gap after each note
        start_song(0);
        beat(0, 0, 1'b1, 0);
        beat(0, 0, 1'b1, 0);
        beat(0, -1, 1'b1, 0);
        beat(0, 2, 1'b1, 1);
        beat(0, -1, 1'b1, 1);
        done_q.push_back(0);
        beat(0, -1, 1'b0, 2);

        // Rest entry stays silent while busy
        start_song(1);
        beat(1, -1, 1'b1, 0);
        beat(1, -1, 1'b1, 0);
        beat(1, -1, 1'b1, 0);
        beat(1, -1, 1'b1, 0);
        beat(1, 4, 1'b1, 1);
        beat(1, -1, 1'b1, 1);
        done_q.push_back(1);
        beat(1, -1, 0, 2);

        // Looping: wraps to entry 0, then ends after loop drops
        loop = 1'b1;
        start_song(0);
        beat(0, 0, 1'b1, 0);
        beat(0, 0, 1'b1, 0);
        beat(0, -1, 1'b1, 0);
        beat(0, 2, 1'b1, 1);
        beat(0, -1, 1'b1, 1);
        beat(0, 0, 1'b1, 0);
        loop = 1'b0;
        beat(0, 0, 1'b1, 0);
        beat(0, -1, 1'b1, 0);
        beat(0, 2, 1'b1, 1);
        beat(0, -1, 1'b1, 1);
        done_q.push_back(0);
        beat(0, -1, 1'b0, 2);

        // Stop mid-note, then start colliding with stop
        start_song(0);
        beat(0, 0, 1'b1, 0);
        tick();
        en  = 1'b0;
        win = 1'b0;
        tick();
        tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        push(0, -1, 1'b0, 0);
        chk = 1'b1;
        tick();
        chk      = 1'b0;
        start[0] = 1'b1;
        stop     = 1'b1;
        tick();
        start[0] = 1'b0;
        stop     = 1'b0;
        check_now(0, 0);

        // Empty table with loop set must finish promptly
        loop = 1'b1;
        done_q.push_back(2);
        start_song(2);
        tick();
        tick();
        tick();
        cmp("empty_done_within_3", 2, done_q.size(), 0);
        check_now(2, 0);
        loop = 1'b0;

        // Asynchronous reset in the gap after the second note
        start_song(0);
        beat(0, 0, 1'b1, 0);
        beat(0, 0, 1'b1, 0);
        beat(0, -1, 1'b1, 0);
        beat(0, 2, 1'b1, 1);
        tick();
        en  = 1'b0;
        win = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        push(0, -1, 1'b0, 0);
        chk = 1'b1;
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        chk   = 1'b0;
        tick();

        // Replay from entry 0 after reset
        start_song(0);
        beat(0, 0, 1'b1, 0);
        beat(0, 0, 1'b1, 0);
        beat(0, -1, 1'b1, 0);
        beat(0, 2, 1'b1, 1);
        beat(0, -1, 1'b1, 1);
        done_q.push_back(0);
        beat(0, -1, 1'b0, 2);

        tick();
        en  = 1'b0;
        win = 1'b0;
        repeat (5) tick();
        cmp("sb_drained", -1, sb.size(), 0);
        cmp("done_drained", -1, done_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
